// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage with a hardware return-address stack.
// Optional build macro FETCH_ERR_HALT_EN: freeze fetch once a stack overflow/underflow is flagged.
module fetch_unit #(
   parameter int PC_W    = 10,
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     s_inc,
   input  logic                     call,
   input  logic                     ret,
   input  logic [PC_W-1:0]          jump_addr,
   output logic [PC_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]       imem_data,
   output logic [PC_W-1:0]          pc,
   output logic [INSTR_W-1:0]       instr,
   output logic                     instr_valid,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     stack_ovf,
   output logic                     stack_unf
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int SP_W  = IDX_W + 1;

   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               vld_q, vld_d;
   logic [SP_W-1:0]    sp_q, sp_d;
   logic               ovf_q, ovf_d;
   logic               unf_q, unf_d;
   logic               first_q, first_d;
   logic [PC_W-1:0]    stack_q [DEPTH];

   logic               push;
   logic               halt;
   logic               full;
   logic               empty;
   logic [SP_W-1:0]    sp_m1;
   logic [PC_W-1:0]    pc_inc;
   logic [PC_W-1:0]    top;

   assign pc_inc = pc_q + PC_W'(1);
   assign sp_m1  = sp_q - SP_W'(1);
   assign full   = (sp_q == SP_W'(DEPTH));
   assign empty  = (sp_q == '0);
   assign top    = stack_q[sp_m1[IDX_W-1:0]];

`ifdef FETCH_ERR_HALT_EN
   assign halt = ovf_q | unf_q;
`else
   assign halt = 1'b0;
`endif

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      vld_d   = vld_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      first_d = first_q;
      push    = 1'b0;
      if (!stall) begin
         instr_d = imem_data;
         vld_d   = 1'b1;
         first_d = 1'b0;
         if (halt) begin
            vld_d = 1'b0;
         end else if (ret) begin
            // ret outranks call, so a simultaneous call neither pushes nor flags overflow
            if (!empty) begin
               pc_d  = top;
               sp_d  = sp_m1;
               vld_d = 1'b0;
            end else begin
               unf_d = 1'b1;
            end
         end else if (call) begin
            if (!full) begin
               push  = 1'b1;
               sp_d  = sp_q + SP_W'(1);
               pc_d  = jump_addr;
               vld_d = 1'b0;
            end else begin
               ovf_d = 1'b1;
            end
         end else if (!s_inc) begin
            pc_d  = jump_addr;
            vld_d = 1'b0;
         end else begin
            pc_d = pc_inc;
         end
         // The word captured on the first edge out of reset is never presented as valid
         if (first_q) vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= '0;
         instr_q <= '0;
         vld_q   <= 1'b0;
         sp_q    <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         first_q <= 1'b1;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         vld_q   <= vld_d;
         sp_q    <= sp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         first_q <= first_d;
      end
   end

   // Stack storage is data only; entries above sp are don't-care
   always_ff @(posedge clk) begin
      if (push) stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = vld_q;
   assign sp          = sp_q;
   assign stack_ovf   = ovf_q;
   assign stack_unf   = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns word = address.
module tb_fetch_unit;

   localparam int PC_W    = 10;
   localparam int INSTR_W = 16;
   localparam int DEPTH   = 8;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               stall = 1'b0;
   logic               s_inc = 1'b1;
   logic               call = 1'b0;
   logic               ret = 1'b0;
   logic [PC_W-1:0]    jump_addr = '0;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_data;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [3:0]         sp;
   logic               stack_ovf;
   logic               stack_unf;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .stall(stall), .s_inc(s_inc), .call(call), .ret(ret),
      .jump_addr(jump_addr), .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
      .instr(instr), .instr_valid(instr_valid), .sp(sp), .stack_ovf(stack_ovf),
      .stack_unf(stack_unf)
   );

   assign imem_data = INSTR_W'(imem_addr);

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      call = 1'b0; ret = 1'b0; s_inc = 1'b1; stall = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic chk_state(input string tag, input logic [PC_W-1:0] e_pc,
                            input logic [INSTR_W-1:0] e_instr, input logic e_vld,
                            input logic [3:0] e_sp);
      check({tag, ".pc"}, 32'(pc), 32'(e_pc));
      check({tag, ".instr"}, 32'(instr), 32'(e_instr));
      check({tag, ".vld"}, 32'(instr_valid), 32'(e_vld));
      check({tag, ".sp"}, 32'(sp), 32'(e_sp));
   endtask

   initial begin
      #1 reset = 1'b0;
      #1;
      chk_state("rst", 10'h000, 16'h0000, 1'b0, 4'd0);
      check("rst.ovf", 32'(stack_ovf), 32'd0);
      check("rst.unf", 32'(stack_unf), 32'd0);
      check("rst.imem_addr", 32'(imem_addr), 32'd0);
      step();
      step();
      reset = 1'b1;

      // Reset and increment
      step(); chk_state("inc1", 10'h001, 16'h0000, 1'b0, 4'd0);
      step(); chk_state("inc2", 10'h002, 16'h0001, 1'b1, 4'd0);
      step(); chk_state("inc3", 10'h003, 16'h0002, 1'b1, 4'd0);
      step(); step();
      check("inc5.pc", 32'(pc), 32'h005);

      // Jump bubble
      s_inc = 1'b0; jump_addr = 10'h3A0;
      step(); chk_state("jmp", 10'h3A0, 16'h0005, 1'b0, 4'd0);
      s_inc = 1'b1;
      step(); chk_state("jmp_next", 10'h3A1, 16'h03A0, 1'b1, 4'd0);

      // Call / return
      s_inc = 1'b0; jump_addr = 10'h010;
      step(); check("to10.pc", 32'(pc), 32'h010);
      s_inc = 1'b1; call = 1'b1; jump_addr = 10'h200;
      step(); chk_state("call", 10'h200, 16'h0010, 1'b0, 4'd1);
      call = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk_state($sformatf("body%0d", i), PC_W'(10'h200 + i), INSTR_W'(16'h01FF + i), 1'b1, 4'd1);
      end
      ret = 1'b1;
      step(); chk_state("ret", 10'h011, 16'h0203, 1'b0, 4'd0);
      ret = 1'b0;
      step(); chk_state("ret_next", 10'h012, 16'h0011, 1'b1, 4'd0);

      // Overflow: 8 nested calls from reset, the last landing at 0x050
      do_reset();
      call = 1'b1;
      for (int i = 0; i < 8; i++) begin
         jump_addr = (i == 7) ? 10'h050 : PC_W'(10'h100 + i);
         step();
         check($sformatf("nest%0d.sp", i), 32'(sp), 32'(i + 1));
      end
      check("nest.pc", 32'(pc), 32'h050);
      check("nest.ovf", 32'(stack_ovf), 32'd0);
      jump_addr = 10'h300;
      step(); chk_state("ovf", 10'h050, 16'h0050, 1'b1, 4'd8);
      check("ovf.flag", 32'(stack_ovf), 32'd1);
      call = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
`ifdef FETCH_ERR_HALT_EN
         check($sformatf("halt%0d.pc", i), 32'(pc), 32'h050);
         check($sformatf("halt%0d.vld", i), 32'(instr_valid), 32'd0);
`else
         check($sformatf("post%0d.pc", i), 32'(pc), 32'(10'h050 + i));
         check($sformatf("post%0d.vld", i), 32'(instr_valid), 32'd1);
`endif
      end
      check("ovf.sticky", 32'(stack_ovf), 32'd1);
`ifndef FETCH_ERR_HALT_EN
      ret = 1'b1;
      step(); chk_state("ovf_pop", 10'h107, 16'h0055, 1'b0, 4'd7);
      ret = 1'b0;
`endif
      // Reset asserted between edges acts immediately
      reset = 1'b0;
      #2;
      chk_state("async_rst", 10'h000, 16'h0000, 1'b0, 4'd0);
      check("async_rst.ovf", 32'(stack_ovf), 32'd0);
      step();
      reset = 1'b1;

      // Underflow
      step(); check("unf_pre.pc", 32'(pc), 32'h001);
      ret = 1'b1;
      step(); chk_state("unf", 10'h001, 16'h0001, 1'b1, 4'd0);
      check("unf.flag", 32'(stack_unf), 32'd1);
      ret = 1'b0;

      // Simultaneous call and ret with sp=2
      do_reset();
      call = 1'b1; jump_addr = 10'h080;
      step();
      jump_addr = 10'h090;
      step(); chk_state("two_calls", 10'h090, 16'h0080, 1'b0, 4'd2);
      ret = 1'b1; jump_addr = 10'h3C0;
      step(); chk_state("callret", 10'h081, 16'h0090, 1'b0, 4'd1);
      check("callret.ovf", 32'(stack_ovf), 32'd0);
      call = 1'b0;
      step(); chk_state("ret2", 10'h001, 16'h0081, 1'b0, 4'd0);
      ret = 1'b0;
      check("ret2.unf", 32'(stack_unf), 32'd0);

      // Stall and wrap
      s_inc = 1'b0; jump_addr = 10'h3FF;
      step(); chk_state("to3ff", 10'h3FF, 16'h0001, 1'b0, 4'd0);
      stall = 1'b1; call = 1'b1; jump_addr = 10'h123;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk_state($sformatf("stall%0d", i), 10'h3FF, 16'h0001, 1'b0, 4'd0);
         check($sformatf("stall%0d.imem_addr", i), 32'(imem_addr), 32'h3FF);
      end
      stall = 1'b0; call = 1'b0; s_inc = 1'b1;
      step(); chk_state("wrap", 10'h000, 16'h03FF, 1'b1, 4'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
